// File: rtl/ihs_pkg.sv
// Shared definitions for the instruction sequencer: widths, step encodings, FSM states, opcodes.
package ihs_pkg;

    localparam int unsigned INSTR_WIDTH = 16;
    localparam int unsigned STEP_WIDTH  = 2;
    localparam int unsigned OP_WIDTH    = 4;

    // Step counter encoding decoded by the control unit
    typedef enum logic [STEP_WIDTH-1:0] {
        STEP_DECODE = 2'b00,
        STEP_LOAD_A = 2'b01,
        STEP_EXEC   = 2'b10,
        STEP_WRITE  = 2'b11
    } step_t;

    // Sequencer FSM states
    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_EXEC = 1'b1
    } seq_state_t;

    // Opcode field values (top nibble of the instruction)
    localparam logic [OP_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OP_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OP_WIDTH-1:0] OP_JMP = 4'h8;
    localparam logic [OP_WIDTH-1:0] OP_LDI = 4'hA;

endpackage

// File: rtl/instr_fifo.sv
// In-order synchronous FIFO; pointers carry one extra wrap bit to tell full from empty.
module instr_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the buffer
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction front end: buffers pushed instructions and steps each one through four control steps.
module instruction_sequencer
    import ihs_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = ihs_pkg::INSTR_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 2
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic                   step_enable,
    input  logic                   clear_counter,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [1:0]             current_state,
    output logic                   busy,
    output logic                   instr_done
);

    seq_state_t             r_state;
    step_t                  r_step;
    logic [INSTR_WIDTH-1:0] r_instr;
    logic                   r_busy;
    logic                   r_done;

    logic [INSTR_WIDTH-1:0] w_dout;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_retire;

    assign w_push = instr_valid && !w_full;

    // Retire on wrap past the last step, or on an early clear once the counter has left step 0
    assign w_retire = (r_state == SEQ_EXEC) &&
                      ((clear_counter && (r_step != STEP_DECODE)) ||
                       (step_enable && (r_step == STEP_WRITE)));

    assign w_pop = !w_empty && ((r_state == SEQ_IDLE) || w_retire);

    instr_fifo #(
        .WIDTH (INSTR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (w_push),
        .pop    (w_pop),
        .din    (instr_in),
        .dout   (w_dout),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Sequencer FSM: load, step, retire, and back-to-back reload
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= SEQ_IDLE;
            r_step  <= STEP_DECODE;
            r_instr <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_retire;
            case (r_state)
                SEQ_IDLE: begin
                    r_step <= STEP_DECODE;
                    if (!w_empty) begin
                        r_instr <= w_dout;
                        r_busy  <= 1'b1;
                        r_state <= SEQ_EXEC;
                    end
                end
                SEQ_EXEC: begin
                    if (w_retire) begin
                        r_step <= STEP_DECODE;
                        if (!w_empty) begin
                            r_instr <= w_dout;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= SEQ_IDLE;
                        end
                    end else if (step_enable) begin
                        r_step <= step_t'(r_step + 2'd1);
                    end
                end
                default: begin
                    r_state <= SEQ_IDLE;
                    r_step  <= STEP_DECODE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign instr_ready   = !w_full;
    assign instruction   = r_instr;
    assign current_state = r_step;
    assign busy          = r_busy;
    assign instr_done    = r_done;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized run vs. queue model.
module tb_instruction_sequencer;

    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 2;

    logic         clock;
    logic         resetn;
    logic [W-1:0] instr_in;
    logic         instr_valid;
    logic         instr_ready;
    logic         step_enable;
    logic         clear_counter;
    logic [W-1:0] instruction;
    logic [1:0]   current_state;
    logic         busy;
    logic         instr_done;

    instruction_sequencer #(
        .INSTR_WIDTH (W),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clock         (clock),
        .resetn        (resetn),
        .instr_in      (instr_in),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .step_enable   (step_enable),
        .clear_counter (clear_counter),
        .instruction   (instruction),
        .current_state (current_state),
        .busy          (busy),
        .instr_done    (instr_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: pending queue plus the executing instruction and its step number
    logic [W-1:0] mq[$];
    logic [W-1:0] m_instr;
    bit           m_busy;
    int           m_step;
    bit           m_done;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        m_instr = '0;
        m_busy  = 1'b0;
        m_step  = 0;
        m_done  = 1'b0;
    endtask

    // One rising edge of the behaviour described for the sequencer
    task automatic model_edge(input bit v, input logic [W-1:0] d, input bit se, input bit clr);
        bit ready;
        bit retire;
        ready  = (mq.size() < DEPTH);
        retire = m_busy && ((clr && m_step != 0) || (se && m_step == 3));
        m_done = retire;
        if (m_busy && !retire && se) m_step = (m_step + 1) % 4;
        if ((!m_busy || retire) && mq.size() > 0) begin
            m_instr = mq.pop_front();
            m_busy  = 1'b1;
            m_step  = 0;
        end else if (retire) begin
            m_busy = 1'b0;
            m_step = 0;
        end
        if (v && ready) mq.push_back(d);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".instruction"}, instruction, m_instr);
        check({tag, ".state"}, W'(current_state), W'(m_step));
        check({tag, ".busy"}, W'(busy), W'(m_busy));
        check({tag, ".done"}, W'(instr_done), W'(m_done));
        check({tag, ".ready"}, W'(instr_ready), W'(mq.size() < DEPTH));
    endtask

    // Drive at the falling edge, step the model at the rising edge, compare at the next falling edge
    task automatic do_cycle(input bit v, input logic [W-1:0] d, input bit se, input bit clr, input string tag);
        instr_valid   = v;
        instr_in      = d;
        step_enable   = se;
        clear_counter = clr;
        @(posedge clock);
        model_edge(v, d, se, clr);
        @(negedge clock);
        check_model(tag);
    endtask

    task automatic apply_reset();
        instr_valid   = 1'b0;
        instr_in      = '0;
        step_enable   = 1'b0;
        clear_counter = 1'b0;
        resetn        = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
    endtask

    typedef struct {
        bit           v;
        logic [W-1:0] d;
        bit           se;
        bit           clr;
        logic [W-1:0] e_instr;
        logic [1:0]   e_state;
        bit           e_busy;
        bit           e_done;
        bit           e_ready;
    } vec_t;

    vec_t vecs[20];

    initial begin
        // LDI single run, then clear-counter and stall behaviour
        vecs[0]  = '{1'b1, 16'hA005, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'hA005, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 16'h2100, 1'b1, 1'b0, 16'hA005, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 16'h8000, 1'b1, 1'b0, 16'h2100, 2'd0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2100, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h2100, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 2'd0, 1'b1, 1'b1, 1'b1};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8000, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h8000, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h8000, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h8000, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 2'd2, 1'b1, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 2'd3, 1'b1, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 2'd0, 1'b0, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8000, 2'd0, 1'b0, 1'b0, 1'b1};

        resetn = 1'b0;
        apply_reset();
        check("reset.instruction", instruction, 16'h0000);
        check("reset.state", W'(current_state), 16'd0);
        check("reset.busy", W'(busy), 16'd0);
        check("reset.done", W'(instr_done), 16'd0);
        check("reset.ready", W'(instr_ready), 16'd1);

        // Directed table against hand-derived expectations
        for (int i = 0; i < 20; i++) begin
            instr_valid   = vecs[i].v;
            instr_in      = vecs[i].d;
            step_enable   = vecs[i].se;
            clear_counter = vecs[i].clr;
            @(posedge clock);
            model_edge(vecs[i].v, vecs[i].d, vecs[i].se, vecs[i].clr);
            @(negedge clock);
            check($sformatf("vec%0d.instruction", i), instruction, vecs[i].e_instr);
            check($sformatf("vec%0d.state", i), W'(current_state), W'(vecs[i].e_state));
            check($sformatf("vec%0d.busy", i), W'(busy), W'(vecs[i].e_busy));
            check($sformatf("vec%0d.done", i), W'(instr_done), W'(vecs[i].e_done));
            check($sformatf("vec%0d.ready", i), W'(instr_ready), W'(vecs[i].e_ready));
        end

        // Three back-to-back pushes fill the buffer; a fourth while full must be dropped
        do_cycle(1'b1, 16'h0080, 1'b1, 1'b0, "b2b.p0");
        do_cycle(1'b1, 16'h2100, 1'b1, 1'b0, "b2b.p1");
        do_cycle(1'b1, 16'h8000, 1'b1, 1'b0, "b2b.p2");
        check("b2b.full_ready", W'(instr_ready), 16'd0);
        do_cycle(1'b1, 16'hFFFF, 1'b1, 1'b0, "b2b.drop");
        for (int i = 0; i < 14; i++) do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "b2b.run");
        check("b2b.last", instruction, 16'h8000);
        check("b2b.idle", W'(busy), 16'd0);

        // Push lands on the same edge a retirement pops the single queued entry
        do_cycle(1'b1, 16'h1111, 1'b1, 1'b0, "sim.p0");
        do_cycle(1'b1, 16'h2222, 1'b1, 1'b0, "sim.p1");
        do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "sim.s1");
        do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "sim.s2");
        do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "sim.s3");
        do_cycle(1'b1, 16'h3333, 1'b1, 1'b0, "sim.pushpop");
        check("sim.loaded", instruction, 16'h2222);
        check("sim.ready", W'(instr_ready), 16'd1);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "sim.drain");

        // Asynchronous reset mid-instruction with two entries queued
        do_cycle(1'b1, 16'h4444, 1'b1, 1'b0, "rst.p0");
        do_cycle(1'b1, 16'h5555, 1'b1, 1'b0, "rst.p1");
        do_cycle(1'b1, 16'h6666, 1'b1, 1'b0, "rst.p2");
        do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "rst.s2");
        check("rst.pre_state", W'(current_state), 16'd2);
        resetn = 1'b0;
        #1;
        check("rst.async.instruction", instruction, 16'h0000);
        check("rst.async.state", W'(current_state), 16'd0);
        check("rst.async.busy", W'(busy), 16'd0);
        check("rst.async.done", W'(instr_done), 16'd0);
        check("rst.async.ready", W'(instr_ready), 16'd1);
        apply_reset();
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 16'h0000, 1'b1, 1'b0, "rst.empty");
        check("rst.still_idle", W'(busy), 16'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            do_cycle(($urandom_range(0, 2) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 7) == 0), "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
